// File: rtl/main_ctrl.sv
// Multicycle MIPS main-control Moore FSM: sequences fetch, decode and the
// per-class execute/memory/writeback steps, driving datapath enables and selects.
module main_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_RTYPE:                 state_d = S_EXECUTE;
          OP_BEQ:                   state_d = S_BRANCH;
          OP_ADDI, OP_ORI, OP_ANDI: state_d = S_IMMEXEC;
          OP_J:                     state_d = S_JUMP;
          default:                  state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_IMMEXEC: state_d = S_IMMWB;
      S_IMMWB:   state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Reset overrides everything combinationally so the datapath sees no enables mid-reset.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 3'b000;
    state    = rst ? 4'd0 : state_q;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE:  alusrcb = 2'b11;
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_EXECUTE: begin
          alusrca = 1'b1;
          aluop   = 3'b010;
        end
        S_ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BRANCH: begin
          alusrca = 1'b1;
          aluop   = 3'b001;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        S_IMMEXEC: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          if (op == OP_ORI)       aluop = 3'b011;
          else if (op == OP_ANDI) aluop = 3'b100;
          else                    aluop = 3'b000;
        end
        S_IMMWB:   regwrite = 1'b1;
        S_JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_main_ctrl.sv
// Randomized bench for main_ctrl: an instruction-level model expands each op
// and its wait counts into the expected per-cycle state/control trace.
module tb_main_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, branch, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int st; bit rdy; } step_t;
  step_t plan[$];

  main_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg),
    .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Packed order: pcwrite,branch,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,pcsrc,aluop
  function automatic logic [16:0] dut_ctrl();
    return {pcwrite, branch, iord, memread, memwrite, irwrite, memtoreg,
            regdst, regwrite, alusrca, alusrcb, pcsrc, aluop};
  endfunction

  function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] o, input bit rdy);
    logic pw = 0, br = 0, id = 0, mr = 0, mw = 0, ir = 0, mtr = 0, rd = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] ao = 0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; ir = rdy; pw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; id = 1; end
      4:  begin mtr = 1; rw = 1; end
      5:  begin mw = 1; id = 1; end
      6:  begin sa = 1; ao = 3'b010; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ao = 3'b001; ps = 2'b01; br = 1; end
      9:  begin sa = 1; sb = 2'b10;
                ao = (o == 6'b001101) ? 3'b011 : (o == 6'b001100) ? 3'b100 : 3'b000; end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    return {pw, br, id, mr, mw, ir, mtr, rd, rw, sa, sb, ps, ao};
  endfunction

  // Entered and left at posedge+1; samples on the falling edge.
  task automatic do_step(input int st, input bit rdy, input logic [5:0] o);
    logic [3:0] e_st;
    mem_ready = rdy;
    @(negedge clk);
    e_st = 4'(st);
    check("state", 32'(state), 32'(e_st));
    check("ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(st, o, rdy)));
    check("excl", 32'($countones({regwrite, memwrite, branch, pcwrite & ~irwrite}) <= 1), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic push(input int st, input bit rdy);
    step_t s;
    s.st = st; s.rdy = rdy;
    plan.push_back(s);
  endtask

  task automatic build_plan(input logic [5:0] o, input int wf, input int wm);
    plan.delete();
    for (int i = 0; i < wf; i++) push(0, 1'b0);
    push(0, 1'b1);
    push(1, 1'($urandom_range(0, 1)));
    case (o)
      6'b100011: begin
        push(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < wm; i++) push(3, 1'b0);
        push(3, 1'b1);
        push(4, 1'($urandom_range(0, 1)));
      end
      6'b101011: begin
        push(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < wm; i++) push(5, 1'b0);
        push(5, 1'b1);
      end
      6'b000000: begin push(6, 1'($urandom_range(0, 1))); push(7, 1'($urandom_range(0, 1))); end
      6'b001000, 6'b001101, 6'b001100: begin
        push(9, 1'($urandom_range(0, 1))); push(10, 1'($urandom_range(0, 1)));
      end
      6'b000100: push(8, 1'($urandom_range(0, 1)));
      6'b000010: push(11, 1'($urandom_range(0, 1)));
      default: ;
    endcase
  endtask

  int txn = 0;

  task automatic run_instr(input logic [5:0] o, input int wf, input int wm);
    build_plan(o, wf, wm);
    op = o;
    foreach (plan[i]) do_step(plan[i].st, plan[i].rdy, o);
    $display("txn %0d op=%b fetch_wait=%0d mem_wait=%0d cycles=%0d", txn, o, wf, wm, plan.size());
    txn++;
  endtask

  logic [5:0] known_ops [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                                6'b001101, 6'b001100, 6'b000010, 6'b111111};

  initial begin
    rst = 1'b1; mem_ready = 1'b1; op = 6'b100011;
    repeat (2) begin
      @(negedge clk);
      check("rst_state", 32'(state), 32'd0);
      check("rst_ctrl", 32'(dut_ctrl()), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b001101, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);

    // Reset while a load is waiting in MEMRD: no resumption, fresh fetch follows.
    op = 6'b100011;
    do_step(0, 1'b1, op);
    do_step(1, 1'b0, op);
    do_step(2, 1'b0, op);
    do_step(3, 1'b0, op);
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_ctrl", 32'(dut_ctrl()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_step(0, 1'b0, op);
    $display("txn %0d reset aborted load in MEMRD", txn);
    txn++;

    for (int k = 0; k < 300; k++) begin
      logic [5:0] o;
      if ($urandom_range(0, 4) == 0) o = 6'($urandom_range(0, 63));
      else o = known_ops[$urandom_range(0, 8)];
      run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
